// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the
// memory-cycle responder and its wait counter.
package mem_resp_pkg;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [3:0] ROM_PAGE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } state_t;

  typedef struct packed {
    logic rom;
    logic rd;
  } cyc_t;

endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with a terminal
// flag raised when one wait state remains.
module wait_counter
  import mem_resp_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == CW'(1));

endmodule

// File: rtl/mem_cycle_responder.sv
// mem_cycle_responder: ROM/RAM bus-cycle responder with wait states.
// MEM_RESP_WRPROT_EN adds address_hi/wrprot_err page-F write protect.
module mem_cycle_responder
  import mem_resp_pkg::*;
#(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 1,
  parameter int DW       = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rom_cs,
  input  logic          ram_cs,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [DW-1:0] rom_dout,
  input  logic [DW-1:0] ram_dout,
`ifdef MEM_RESP_WRPROT_EN
  input  logic [15:12]  address_hi,
  output logic          wrprot_err,
`endif
  output logic [DW-1:0] cpu_din,
  output logic          cpu_wait_n,
  output logic          ram_we,
  output logic          cycle_done,
  output logic          cs_conflict
);

  if (ROM_WAIT < 0 || ROM_WAIT > CNT_MAX ||
      RAM_WAIT < 0 || RAM_WAIT > CNT_MAX) begin : g_bad_wait
    $error("wait-state parameter outside 0..15");
  end

  localparam logic [CW-1:0] ROM_W = CW'(ROM_WAIT);
  localparam logic [CW-1:0] RAM_W = CW'(RAM_WAIT);

  state_t        state, state_nx;
  cyc_t          cyc, cyc_nx;
  logic          active, req;
  logic          ld, dec, tc;
  logic [CW-1:0] ld_val;
  logic          wait_nx, done_nx;
  logic          din_ld, ram_wr;
  logic          conf_set, prot_hit;

  assign active = memread | memwrite;
  assign req    = (rom_cs | ram_cs) & active;
  assign ld_val = rom_cs ? ROM_W : RAM_W;

`ifdef MEM_RESP_WRPROT_EN
  assign prot_hit = (address_hi == ROM_PAGE);
`else
  assign prot_hit = 1'b0;
`endif

  wait_counter u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (ld),
    .dec      (dec),
    .load_val (ld_val),
    .tc       (tc)
  );

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    ld       = 1'b0;
    dec      = 1'b0;
    wait_nx  = 1'b1;
    done_nx  = 1'b0;
    din_ld   = 1'b0;
    ram_wr   = 1'b0;
    conf_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          cyc_nx.rom = rom_cs;
          cyc_nx.rd  = memread;
          conf_set   = rom_cs & ram_cs;
          ld         = 1'b1;
          if (ld_val != '0) begin
            state_nx = WAIT;
            wait_nx  = 1'b0;
          end else begin
            state_nx = ACK;
          end
        end
      end
      WAIT: begin
        // abort wins over terminal count
        if (!active) begin
          state_nx = IDLE;
        end else if (tc) begin
          state_nx = ACK;
          dec      = 1'b1;
        end else begin
          wait_nx  = 1'b0;
          dec      = 1'b1;
        end
      end
      ACK: begin
        state_nx = HOLD;
        done_nx  = 1'b1;
        din_ld   = cyc.rd;
        ram_wr   = ~cyc.rd & ~cyc.rom;
      end
      HOLD: begin
        if (!active) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cyc         <= '0;
      cpu_din     <= '0;
      cpu_wait_n  <= 1'b1;
      ram_we      <= 1'b0;
      cycle_done  <= 1'b0;
      cs_conflict <= 1'b0;
    end else begin
      state       <= state_nx;
      cyc         <= cyc_nx;
      cpu_wait_n  <= wait_nx;
      ram_we      <= ram_wr & ~prot_hit;
      cycle_done  <= done_nx;
      cs_conflict <= cs_conflict | conf_set;
      if (din_ld) cpu_din <= cyc.rom ? rom_dout : ram_dout;
    end
  end

`ifdef MEM_RESP_WRPROT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wrprot_err <= 1'b0;
    else          wrprot_err <= wrprot_err | (ram_wr & prot_hit);
  end
`endif

endmodule

// File: tb/tb_mem_cycle_responder.sv
// tb_mem_cycle_responder: randomized self-checking bench
// comparing bus-cycle behaviour against a cycle-level model.
module tb_mem_cycle_responder;

  localparam int ROM_N = 2;
  localparam int RAM_N = 1;

  logic       clock = 0;
  logic       reset_n = 0;
  logic       rom_cs = 0, ram_cs = 0;
  logic       memread = 0, memwrite = 0;
  logic [7:0] rom_dout = 0, ram_dout = 0;
  logic [7:0] cpu_din;
  logic       cpu_wait_n, ram_we, cycle_done, cs_conflict;
`ifdef MEM_RESP_WRPROT_EN
  logic [3:0] address_hi = 0;
  logic       wrprot_err;
  logic       model_prot = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] model_din = 0;
  logic       model_conf = 0;

  always #5 clock = ~clock;

  mem_cycle_responder #(
    .ROM_WAIT (ROM_N),
    .RAM_WAIT (RAM_N),
    .DW       (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rom_cs      (rom_cs),
    .ram_cs      (ram_cs),
    .memread     (memread),
    .memwrite    (memwrite),
    .rom_dout    (rom_dout),
    .ram_dout    (ram_dout),
`ifdef MEM_RESP_WRPROT_EN
    .address_hi  (address_hi),
    .wrprot_err  (wrprot_err),
`endif
    .cpu_din     (cpu_din),
    .cpu_wait_n  (cpu_wait_n),
    .ram_we      (ram_we),
    .cycle_done  (cycle_done),
    .cs_conflict (cs_conflict)
  );

  // Drive one bus cycle for `hold` clocks, release, and observe.
  task automatic run_cycle(
    input  bit rom, input bit ram,
    input  bit rd,  input bit wr,
    input  int hold,
    output int wlow, output int dones,
    output int wes,  output int didx,
    output logic [7:0] ddone
  );
    wlow = 0; dones = 0; wes = 0; didx = -1; ddone = 'x;
    rom_cs = rom; ram_cs = ram; memread = rd; memwrite = wr;
    for (int i = 0; i < hold + 3; i++) begin
      @(posedge clock); #1;
      if (!cpu_wait_n) wlow++;
      if (cycle_done) begin
        dones++; didx = i; ddone = cpu_din;
      end
      if (ram_we) wes++;
      if (i == hold - 1) begin
        rom_cs = 0; ram_cs = 0; memread = 0; memwrite = 0;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (cpu_wait_n !== 1'b1) begin errors++;
      $display("FAIL rst_wait got %b want 1", cpu_wait_n); end
    checks++; if (cpu_din !== 8'h00) begin errors++;
      $display("FAIL rst_din got %h want 00", cpu_din); end
    checks++; if (ram_we !== 1'b0) begin errors++;
      $display("FAIL rst_we got %b want 0", ram_we); end
    checks++; if (cycle_done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", cycle_done); end
    checks++; if (cs_conflict !== 1'b0) begin errors++;
      $display("FAIL rst_conf got %b want 0", cs_conflict); end
    reset_n = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_ram_read;
    int wl, dn, we, di;
    logic [7:0] dd;
    ram_dout = 8'hA5; rom_dout = 8'h11;
    run_cycle(0, 1, 1, 0, 4, wl, dn, we, di, dd);
    model_din = 8'hA5;
    checks++; if (wl != RAM_N) begin errors++;
      $display("FAIL ram_rd_wait got %0d want %0d", wl, RAM_N); end
    checks++; if (dn != 1 || di != RAM_N + 1) begin errors++;
      $display("FAIL ram_rd_done got n=%0d at %0d want 1 at %0d",
               dn, di, RAM_N + 1); end
    checks++; if (dd !== 8'hA5) begin errors++;
      $display("FAIL ram_rd_data got %h want a5", dd); end
    checks++; if (we != 0) begin errors++;
      $display("FAIL ram_rd_we got %0d want 0", we); end
  endtask

  task automatic test_rom_read;
    int wl, dn, we, di;
    logic [7:0] dd;
    rom_dout = 8'h3C; ram_dout = 8'h77;
    run_cycle(1, 0, 1, 0, 5, wl, dn, we, di, dd);
    model_din = 8'h3C;
    checks++; if (wl != ROM_N) begin errors++;
      $display("FAIL rom_rd_wait got %0d want %0d", wl, ROM_N); end
    checks++; if (dn != 1 || di != ROM_N + 1) begin errors++;
      $display("FAIL rom_rd_done got n=%0d at %0d want 1 at %0d",
               dn, di, ROM_N + 1); end
    checks++; if (dd !== 8'h3C || cpu_din !== 8'h3C) begin errors++;
      $display("FAIL rom_rd_data got %h/%h want 3c", dd, cpu_din); end
  endtask

  task automatic test_ram_write_long;
    int wl, dn, we, di;
    logic [7:0] dd;
    run_cycle(0, 1, 0, 1, 6, wl, dn, we, di, dd);
    checks++; if (we != 1) begin errors++;
      $display("FAIL wr_long_we got %0d want 1", we); end
    checks++; if (dn != 1) begin errors++;
      $display("FAIL wr_long_done got %0d want 1", dn); end
    checks++; if (wl != RAM_N) begin errors++;
      $display("FAIL wr_long_wait got %0d want %0d", wl, RAM_N); end
    checks++; if (cpu_din !== model_din) begin errors++;
      $display("FAIL wr_long_din got %h want %h", cpu_din, model_din); end
  endtask

  task automatic test_abort;
    int dn = 0, we = 0;
    rom_cs = 1; memread = 1;
    @(posedge clock); #1;
    checks++; if (cpu_wait_n !== 1'b0) begin errors++;
      $display("FAIL abort_enter got %b want 0", cpu_wait_n); end
    rom_cs = 0; memread = 0;
    @(posedge clock); #1;
    checks++; if (cpu_wait_n !== 1'b1) begin errors++;
      $display("FAIL abort_wait got %b want 1", cpu_wait_n); end
    repeat (4) begin
      @(posedge clock); #1;
      if (cycle_done) dn++;
      if (ram_we) we++;
    end
    checks++; if (dn != 0 || we != 0) begin errors++;
      $display("FAIL abort_pulses got done=%0d we=%0d want 0", dn, we); end
  endtask

  task automatic test_random;
    int wl, dn, we, di, n, hold, dir;
    bit rom, rd, wr, exp_we;
    logic [7:0] dd;
    repeat (24) begin
      rom = 1'($urandom_range(0, 1));
      dir = $urandom_range(0, 2);
      rd = (dir != 1);
      wr = (dir != 0);
      rom_dout = 8'($urandom);
      ram_dout = 8'($urandom);
`ifdef MEM_RESP_WRPROT_EN
      address_hi = 4'($urandom_range(0, 14));
`endif
      n = rom ? ROM_N : RAM_N;
      hold = n + 3 + $urandom_range(0, 3);
      exp_we = wr && !rd && !rom;
      run_cycle(rom, !rom, rd, wr, hold, wl, dn, we, di, dd);
      if (rd) model_din = rom ? rom_dout : ram_dout;
      checks++; if (wl != n) begin errors++;
        $display("FAIL rnd_wait got %0d want %0d", wl, n); end
      checks++; if (dn != 1 || di != n + 1) begin errors++;
        $display("FAIL rnd_done got n=%0d at %0d want 1 at %0d",
                 dn, di, n + 1); end
      checks++; if (we != int'(exp_we)) begin errors++;
        $display("FAIL rnd_we got %0d want %0d", we, exp_we); end
      checks++; if (cpu_din !== model_din) begin errors++;
        $display("FAIL rnd_din got %h want %h", cpu_din, model_din); end
      checks++; if (cs_conflict !== model_conf) begin errors++;
        $display("FAIL rnd_conf got %b want %b", cs_conflict, model_conf); end
    end
  endtask

  task automatic test_conflict;
    int wl, dn, we, di;
    logic [7:0] dd;
    rom_dout = 8'h5A; ram_dout = 8'hC3;
    run_cycle(1, 1, 1, 0, 5, wl, dn, we, di, dd);
    model_din = 8'h5A; model_conf = 1;
    checks++; if (dd !== 8'h5A) begin errors++;
      $display("FAIL conf_data got %h want 5a", dd); end
    checks++; if (wl != ROM_N) begin errors++;
      $display("FAIL conf_wait got %0d want %0d", wl, ROM_N); end
    run_cycle(0, 1, 1, 0, 4, wl, dn, we, di, dd);
    model_din = ram_dout;
    checks++; if (cs_conflict !== 1'b1) begin errors++;
      $display("FAIL conf_sticky got %b want 1", cs_conflict); end
  endtask

`ifdef MEM_RESP_WRPROT_EN
  task automatic test_wrprot;
    int wl, dn, we, di;
    logic [7:0] dd;
    address_hi = 4'hF;
    run_cycle(0, 1, 0, 1, 5, wl, dn, we, di, dd);
    model_prot = 1;
    checks++; if (we != 0) begin errors++;
      $display("FAIL wrprot_we got %0d want 0", we); end
    checks++; if (wrprot_err !== 1'b1) begin errors++;
      $display("FAIL wrprot_err got %b want 1", wrprot_err); end
    checks++; if (dn != 1) begin errors++;
      $display("FAIL wrprot_done got %0d want 1", dn); end
    address_hi = 4'h3;
    run_cycle(0, 1, 0, 1, 5, wl, dn, we, di, dd);
    checks++; if (we != 1 || wrprot_err !== model_prot) begin errors++;
      $display("FAIL wrprot_after got we=%0d err=%b want 1/1",
               we, wrprot_err); end
  endtask
`endif

  task automatic test_async_reset;
    int we = 0, wl, dn, di, wes;
    logic [7:0] dd;
    ram_cs = 1; memwrite = 1;
    @(posedge clock); #1;
    checks++; if (cpu_wait_n !== 1'b0) begin errors++;
      $display("FAIL areset_enter got %b want 0", cpu_wait_n); end
    #2 reset_n = 0;
    #1;
    model_din = 0; model_conf = 0;
    checks++; if (cpu_wait_n !== 1'b1 || ram_we !== 1'b0) begin errors++;
      $display("FAIL areset_now got wait=%b we=%b want 1/0",
               cpu_wait_n, ram_we); end
    checks++; if (cpu_din !== 8'h00 || cs_conflict !== 1'b0) begin errors++;
      $display("FAIL areset_regs got din=%h conf=%b want 00/0",
               cpu_din, cs_conflict); end
`ifdef MEM_RESP_WRPROT_EN
    checks++; if (wrprot_err !== 1'b0) begin errors++;
      $display("FAIL areset_prot got %b want 0", wrprot_err); end
`endif
    @(posedge clock); #1;
    ram_cs = 0; memwrite = 0;
    #2 reset_n = 1;
    repeat (4) begin
      @(posedge clock); #1;
      if (ram_we) we++;
    end
    checks++; if (we != 0) begin errors++;
      $display("FAIL areset_we got %0d want 0", we); end
    ram_dout = 8'h96;
    run_cycle(0, 1, 1, 0, 4, wl, dn, wes, di, dd);
    checks++; if (wl != RAM_N || dd !== 8'h96) begin errors++;
      $display("FAIL areset_idle got wait=%0d data=%h want %0d/96",
               wl, dd, RAM_N); end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_rom_read();
    test_ram_write_long();
    test_abort();
    test_random();
    test_conflict();
`ifdef MEM_RESP_WRPROT_EN
    test_wrprot();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
